// File: rtl/axil_pkg.sv
// -----------------------------------------------------------------------------
// axil_pkg
// Shared types and helpers for the AXI4-Lite register bank.
//   axil_resp_t  : AXI response encoding (OKAY/EXOKAY/SLVERR/DECERR)
//   axil_prot_t  : AxPROT field and its bit positions
//   wr_state_t   : write-channel FSM states
//   rd_state_t   : read-channel FSM states
//   clog2_bytes  : number of byte-offset address bits for a data width
//   idx_width    : width of a register index for a given register count
// -----------------------------------------------------------------------------
package axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axil_resp_t;

  typedef logic [2:0] axil_prot_t;

  // AxPROT bit meanings: [0] privileged, [1] non-secure, [2] instruction.
  localparam int unsigned PROT_PRIV_BIT   = 0;
  localparam int unsigned PROT_NONSEC_BIT = 1;
  localparam int unsigned PROT_INSTR_BIT  = 2;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_EXEC = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

  function automatic int unsigned clog2_bytes(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  // A single-register bank still needs a 1-bit index signal.
  function automatic int unsigned idx_width(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/axil_reg_bank_decode.sv
// -----------------------------------------------------------------------------
// axil_reg_bank_decode
// Combinational address / permission checker for one AXI4-Lite channel.
// Ports:
//   addr_i : byte address of the access
//   prot_i : AxPROT of the access
//   idx_o  : register index (addr >> byte-offset bits)
//   resp_o : OKAY, or the error this access must be answered with
// Priority: misaligned (SLVERR) > out of range (DECERR) > read-only write or
// privilege violation (SLVERR).
// Optional: `define AXIL_REG_BANK_PROT_CHECK_EN enables the privilege check
// (prot[0]=0 to a PRIV_MASK register -> SLVERR).
// -----------------------------------------------------------------------------
module axil_reg_bank_decode
  import axil_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          NUM_REGS   = 16,
  parameter int unsigned          IDX_W      = 4,
  parameter bit                   IS_WRITE   = 1'b0,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]  PRIV_MASK  = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  axil_prot_t            prot_i,
  output logic [IDX_W-1:0]      idx_o,
  output axil_resp_t            resp_o
);

  localparam int unsigned LSB = clog2_bytes(DATA_WIDTH);

  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  ro_viol;
  logic                  priv_viol;
  logic                  priv_chk;
  logic                  unused_prot;

  assign word_addr    = addr_i >> LSB;
  assign misaligned   = |addr_i[LSB-1:0];
  // Compare the whole word address so aliases above the bank are rejected.
  assign out_of_range = (word_addr >= ADDR_WIDTH'(NUM_REGS));
  assign idx_o        = word_addr[IDX_W-1:0];

  assign ro_viol   = IS_WRITE && RO_MASK[idx_o];
  assign priv_viol = PRIV_MASK[idx_o] && !prot_i[PROT_PRIV_BIT];

`ifdef AXIL_REG_BANK_PROT_CHECK_EN
  assign priv_chk = priv_viol;
`else
  logic unused_priv;
  assign unused_priv = priv_viol;
  assign priv_chk    = 1'b0;
`endif

  // Only prot[0] carries meaning here; the other bits are accepted as-is.
  assign unused_prot = ^prot_i;

  always_comb begin
    resp_o = RESP_OKAY;
    if (misaligned) begin
      resp_o = RESP_SLVERR;
    end else if (out_of_range) begin
      resp_o = RESP_DECERR;
    end else if (ro_viol || priv_chk) begin
      resp_o = RESP_SLVERR;
    end
  end

endmodule

// File: rtl/axil_reg_bank.sv
// -----------------------------------------------------------------------------
// axil_reg_bank
// AXI4-Lite slave register bank with NUM_REGS registers of DATA_WIDTH bits.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   s_aw* / s_w* / s_b* : AXI4-Lite write address, data and response channels
//   s_ar* / s_r*        : AXI4-Lite read address and data channels
//   reg_out             : flattened RW register contents (RO slots read 0)
//   reg_in              : fabric values returned for RO registers
//   wr_pulse / rd_pulse : one-cycle strobe per successful write / read
// Write path: W_IDLE collects AW and W independently, W_EXEC commits byte-wise
// and loads the response, W_RESP holds B until accepted.
// Read path: R_IDLE registers data/response on AR handshake, R_RESP holds R.
// Optional: `define AXIL_REG_BANK_PROT_CHECK_EN enables PRIV_MASK checking.
// -----------------------------------------------------------------------------
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            NUM_REGS    = 16,
  parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0,
  parameter logic [NUM_REGS-1:0]    PRIV_MASK   = '0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  // write address
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic [2:0]                     s_awprot,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  // write data
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  // write response
  output logic [1:0]                     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  // read address
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic [2:0]                     s_arprot,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  // read data
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  // fabric side
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse,
  output logic [NUM_REGS-1:0]            rd_pulse
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = idx_width(NUM_REGS);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("axil_reg_bank: DATA_WIDTH must be 32 or 64");
  end
  if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_bad_count
    $error("axil_reg_bank: NUM_REGS must be in 1..256");
  end

  // ---------------------------------------------------------------------------
  // Write channel state
  // ---------------------------------------------------------------------------
  wr_state_t             wr_state_q, wr_state_d;
  logic                  aw_held_q,  aw_held_d;
  logic                  w_held_q,   w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q,   awaddr_d;
  axil_prot_t            awprot_q,   awprot_d;
  logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
  logic [STRB_W-1:0]     wstrb_q,    wstrb_d;
  logic                  awready_q,  awready_d;
  logic                  wready_q,   wready_d;
  logic                  bvalid_q,   bvalid_d;
  axil_resp_t            bresp_q,    bresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  logic [IDX_W-1:0]      wr_idx;
  axil_resp_t            wr_resp;
  logic                  wr_commit;

  // ---------------------------------------------------------------------------
  // Read channel state
  // ---------------------------------------------------------------------------
  rd_state_t             rd_state_q, rd_state_d;
  logic                  arready_q,  arready_d;
  logic                  rvalid_q,   rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
  axil_resp_t            rresp_q,    rresp_d;
  logic [NUM_REGS-1:0]   rd_pulse_q, rd_pulse_d;

  logic [IDX_W-1:0]      rd_idx;
  axil_resp_t            rd_resp;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat;

  // ---------------------------------------------------------------------------
  // Decoders: the write side checks the captured address, the read side the
  // live AR address since it responds in the handshake cycle.
  // ---------------------------------------------------------------------------
  axil_reg_bank_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W),
    .IS_WRITE   (1'b1),
    .RO_MASK    (RO_MASK),
    .PRIV_MASK  (PRIV_MASK)
  ) u_wr_decode (
    .addr_i (awaddr_q),
    .prot_i (awprot_q),
    .idx_o  (wr_idx),
    .resp_o (wr_resp)
  );

  axil_reg_bank_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W),
    .IS_WRITE   (1'b0),
    .RO_MASK    (RO_MASK),
    .PRIV_MASK  (PRIV_MASK)
  ) u_rd_decode (
    .addr_i (s_araddr),
    .prot_i (s_arprot),
    .idx_o  (rd_idx),
    .resp_o (rd_resp)
  );

  assign wr_commit = (wr_state_q == W_EXEC) && (wr_resp == RESP_OKAY);

  // ---------------------------------------------------------------------------
  // Register storage: RW slots hold state, RO slots contribute zeros to
  // reg_out and are served from reg_in on reads.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (RO_MASK[gi]) begin : g_ro
      assign reg_flat[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] reg_q, reg_d;
      logic                  hit;

      assign hit = wr_commit && (wr_idx == IDX_W'(gi));

      always_comb begin
        reg_d = reg_q;
        if (hit) begin
          for (int k = 0; k < STRB_W; k++) begin
            if (wstrb_q[k]) begin
              reg_d[k*8 +: 8] = wdata_q[k*8 +: 8];
            end
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          reg_q <= RESET_VALUE;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign reg_flat[gi*DATA_WIDTH +: DATA_WIDTH] = reg_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    awprot_d   = awprot_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;

    unique case (wr_state_q)
      W_IDLE: begin
        if (s_awvalid && awready_q) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_awaddr;
          awprot_d  = s_awprot;
        end
        if (s_wvalid && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = s_wdata;
          wstrb_d  = s_wstrb;
        end
        // Each ready drops as soon as its half is captured; also raises both
        // readies in the first cycle after reset.
        if (aw_held_d && w_held_d) begin
          wr_state_d = W_EXEC;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
        end else begin
          awready_d = !aw_held_d;
          wready_d  = !w_held_d;
        end
      end

      W_EXEC: begin
        bvalid_d   = 1'b1;
        bresp_d    = wr_resp;
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
        wr_state_d = W_RESP;
        if (wr_resp == RESP_OKAY) begin
          wr_pulse_d[wr_idx] = 1'b1;
        end
      end

      W_RESP: begin
        if (s_bready) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = W_IDLE;
        end
      end

      default: begin
        wr_state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state_q <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      awprot_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      awprot_q   <= awprot_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM. Storage is sampled before any same-cycle W_EXEC commit lands,
  // so a coincident read returns the pre-write value.
  // ---------------------------------------------------------------------------
  assign rd_word = RO_MASK[rd_idx] ? reg_in[rd_idx*DATA_WIDTH +: DATA_WIDTH]
                                   : reg_flat[rd_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_pulse_d = '0;

    unique case (rd_state_q)
      R_IDLE: begin
        if (s_arvalid && arready_q) begin
          rvalid_d   = 1'b1;
          arready_d  = 1'b0;
          rresp_d    = rd_resp;
          rd_state_d = R_RESP;
          if (rd_resp == RESP_OKAY) begin
            rdata_d            = rd_word;
            rd_pulse_d[rd_idx] = 1'b1;
          end else begin
            rdata_d = '0;
          end
        end else begin
          arready_d = 1'b1;
        end
      end

      R_RESP: begin
        if (s_rready) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = R_IDLE;
        end
      end

      default: begin
        rd_state_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rd_pulse_q <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign reg_out   = reg_flat;
  assign wr_pulse  = wr_pulse_q;
  assign rd_pulse  = rd_pulse_q;

endmodule

// File: doc/axil_reg_bank.md
Name: axil_reg_bank

Overview:
Parametrised AXI4-Lite slave register bank with configurable data width, register count and per-register read-only mask.
- Terminates an AXI4-Lite master: a CPU bridge, or the AXIL master BFM in simulation.
- Exposes every register to fabric logic as parallel outputs, with per-register write and read strobes.
- Read-only registers reflect fabric-supplied inputs.
- Returns SLVERR/DECERR responses for illegal accesses instead of silently dropping them.

Parameters:
ADDR_WIDTH, 32, AXI address width.
DATA_WIDTH, 32, bus/register width; 32 or 64 only (elaboration $error otherwise).
NUM_REGS, 16, number of registers; 1..256.
RO_MASK, '0, NUM_REGS bits; bit i=1 makes register i read-only (value from reg_in).
RESET_VALUE, '0, DATA_WIDTH reset value applied to every RW register.
PRIV_MASK, '0, NUM_REGS bits; privileged-only registers (used only with the optional feature).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
s_awaddr  in  ADDR_WIDTH  write address
s_awprot  in  3  write protection
s_awvalid/s_awready  in/out  1  AW handshake
s_wdata  in  DATA_WIDTH  write data
s_wstrb  in  DATA_WIDTH/8  byte strobes
s_wvalid/s_wready  in/out  1  W handshake
s_bresp  out  2  write response
s_bvalid/s_bready  out/in  1  B handshake
s_araddr  in  ADDR_WIDTH  read address
s_arprot  in  3  read protection
s_arvalid/s_arready  in/out  1  AR handshake
s_rdata  out  DATA_WIDTH  read data
s_rresp  out  2  read response
s_rvalid/s_rready  out/in  1  R handshake
reg_out  out  NUM_REGS*DATA_WIDTH  current RW register contents, flattened (register i at bits [i*DATA_WIDTH +: DATA_WIDTH])
reg_in  in  NUM_REGS*DATA_WIDTH  fabric values for RO registers; ignored for RW
wr_pulse  out  NUM_REGS  one-cycle strobe on a successful write to register i
rd_pulse  out  NUM_REGS  one-cycle strobe on a successful read of register i

Behaviour:
- Reset (reset_n low, asynchronous):
  - all ready/valid outputs 0; bresp, rresp, rdata 0; pulses 0.
  - RW registers take RESET_VALUE; RO positions of reg_out read 0.
  - Any in-flight transaction is abandoned with no response.
- Decode:
  - LSB = log2(DATA_WIDTH/8); index = addr >> LSB.
  - addr[LSB-1:0] != 0 gives SLVERR (2'b10).
  - index >= NUM_REGS gives DECERR (2'b11).
  - Write to an RO register gives SLVERR, with no update and no wr_pulse.
  - Otherwise OKAY (2'b00).
- Write FSM (W_IDLE, W_EXEC, W_RESP):
  - W_IDLE: awready=1 until AW is captured and wready=1 until W is captured, independently. AW and W may arrive in either order or in the same cycle.
  - Once both are held, go to W_EXEC.
  - W_EXEC (one cycle): commit byte-wise, so byte k is updated only where wstrb[k]=1. wstrb=0 is a legal no-op with OKAY. Pulse wr_pulse[index] for OKAY only. Load bresp and raise bvalid, then go to W_RESP.
  - W_RESP: hold bvalid and bresp until bready, then go to W_IDLE.
  - Latency: bvalid is asserted 2 cycles after the later of the AW/W handshakes.
  - awready and wready are 0 in W_EXEC and W_RESP.
- Read FSM (R_IDLE, R_RESP):
  - R_IDLE: arready=1. On handshake, register rdata, rresp and rd_pulse[index] (OKAY only), raise rvalid, go to R_RESP.
  - rvalid is asserted 1 cycle after the AR handshake.
  - R_RESP: arready=0; hold rdata/rresp until rready, then go to R_IDLE.
  - Read data: RO registers return reg_in sampled at the AR handshake; errored reads return rdata=0.
- Channels are fully independent. A read whose AR handshake coincides with the W_EXEC commit returns the pre-write value.
- bvalid/rvalid never deassert without a ready handshake, except on reset.
- At most one outstanding write and one outstanding read.

Optional Feature:
AXIL_REG_BANK_PROT_CHECK_EN:
- Defined: an access with prot[0]=0 (unprivileged) to a register with PRIV_MASK bit set returns SLVERR, performs no update and raises no pulse. This check ranks after DECERR and the misalignment check.
- Undefined: awprot/arprot and PRIV_MASK are ignored entirely.

Decomposition:
- Shared package axil_pkg:
  - axil_resp_t enum (OKAY, EXOKAY, SLVERR, DECERR)
  - axil_prot_t and its prot-bit constants
  - write-FSM and read-FSM state enums
  - function clog2_bytes(DATA_WIDTH)
- One natural sub-module: axil_reg_bank_decode, a combinational address/permission checker returning {index, resp}. It is instantiated twice, once per channel.

Test Plan:
- Write 0xDEADBEEF to addr 0x8, wstrb 4'hF, AW before W by 3 cycles → bresp OKAY, reg_out[2]=0xDEADBEEF, wr_pulse[2] for one cycle, bvalid 2 cycles after the W handshake.
- Reg 1 holds 0x11223344; write 0xAABBCCDD to addr 0x4 with wstrb 4'b0101 → reg_out[1]=0x11BB33DD; read back gives rdata 0x11BB33DD, OKAY.
- Read addr 0x4*NUM_REGS → DECERR, rdata 0. Write addr 0x2 → SLVERR, with no change and no pulse.
- RO_MASK bit 3 set, reg_in[3]=0x5A5A0000:
  - write to 0xC gives SLVERR;
  - read of 0xC gives 0x5A5A0000 OKAY and rd_pulse[3].
- Hold bready/rready low 10 cycles, with random waits in the master BFM → bvalid/rvalid/data stable throughout; no second AR accepted.
- Assert reset_n low in W_RESP → bvalid drops immediately, registers return to RESET_VALUE, and a subsequent write completes normally.
